// File: rtl/cpu_qsys_cpu_div_cell.sv
// Iterative radix-2 restoring divider: one quotient bit per clock, signed or unsigned,
// returns quotient, remainder and divide-by-zero flag with a one-cycle done strobe.
module cpu_qsys_cpu_div_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             A_div_start,
    input  logic             A_div_signed,
    input  logic [WIDTH-1:0] A_div_src1,
    input  logic [WIDTH-1:0] A_div_src2,
    output logic             A_div_busy,
    output logic             A_div_done,
    output logic [WIDTH-1:0] A_div_quot,
    output logic [WIDTH-1:0] A_div_rem,
    output logic             A_div_dbz,
    output logic [2:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_ITER  = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             op_signed;
    logic             neg_q;
    logic             neg_r;
    logic             dbz_pend;
    logic [WIDTH-1:0] div_mag;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH:0]   work_r;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    assign dbg_state = state;

    // Magnitudes wrap at WIDTH bits, so the most negative value maps onto itself.
    always_comb begin
        mag1    = (op_signed && op1[WIDTH-1]) ? (~op1 + 1'b1) : op1;
        mag2    = (op_signed && op2[WIDTH-1]) ? (~op2 + 1'b1) : op2;
        shifted = {work_r[WIDTH-1:0], work_q[WIDTH-1]};
        trial   = shifted - {1'b0, div_mag};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            A_div_busy <= 1'b0;
            A_div_done <= 1'b0;
            A_div_quot <= '0;
            A_div_rem  <= '0;
            A_div_dbz  <= 1'b0;
            op1        <= '0;
            op2        <= '0;
            op_signed  <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            dbz_pend   <= 1'b0;
            div_mag    <= '0;
            work_q     <= '0;
            work_r     <= '0;
            count      <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    A_div_done <= 1'b0;
                    if (A_div_start) begin
                        op1        <= A_div_src1;
                        op2        <= A_div_src2;
                        op_signed  <= A_div_signed;
                        A_div_busy <= 1'b1;
                        state      <= S_SETUP;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SETUP: begin
                    neg_q    <= op_signed & (op1[WIDTH-1] ^ op2[WIDTH-1]);
                    neg_r    <= op_signed & op1[WIDTH-1];
                    work_q   <= mag1;
                    div_mag  <= mag2;
                    work_r   <= '0;
                    count    <= CW'(WIDTH - 1);
                    dbz_pend <= (op2 == '0);
                    state    <= S_ITER;
                end
                S_ITER: begin
                    // Restore by keeping the shifted value when the trial goes negative.
                    if (trial[WIDTH]) begin
                        work_r <= shifted;
                        work_q <= {work_q[WIDTH-2:0], 1'b0};
                    end else begin
                        work_r <= trial;
                        work_q <= {work_q[WIDTH-2:0], 1'b1};
                    end
                    count <= count - CW'(1);
                    if (count == '0) begin
                        state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    A_div_dbz <= dbz_pend;
                    if (dbz_pend) begin
                        A_div_quot <= '1;
                        A_div_rem  <= op1;
                    end else begin
                        A_div_quot <= neg_q ? (~work_q + 1'b1) : work_q;
                        A_div_rem  <= neg_r ? (~work_r[WIDTH-1:0] + 1'b1) : work_r[WIDTH-1:0];
                    end
                    A_div_busy <= 1'b0;
                    A_div_done <= 1'b1;
                    state      <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_qsys_cpu_div_cell.sv
// Bench for cpu_qsys_cpu_div_cell: directed and random divides against an arithmetic model,
// with latency, busy window, ignored starts, back-to-back and mid-operation reset.
module tb_cpu_qsys_cpu_div_cell;

    localparam int W = 32;
    localparam int LAT = W + 3;

    logic         clk;
    logic         reset;
    logic         A_div_start;
    logic         A_div_signed;
    logic [W-1:0] A_div_src1;
    logic [W-1:0] A_div_src2;
    logic         A_div_busy;
    logic         A_div_done;
    logic [W-1:0] A_div_quot;
    logic [W-1:0] A_div_rem;
    logic         A_div_dbz;
    logic [2:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    cpu_qsys_cpu_div_cell #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .A_div_start  (A_div_start),
        .A_div_signed (A_div_signed),
        .A_div_src1   (A_div_src1),
        .A_div_src2   (A_div_src2),
        .A_div_busy   (A_div_busy),
        .A_div_done   (A_div_done),
        .A_div_quot   (A_div_quot),
        .A_div_rem    (A_div_rem),
        .A_div_dbz    (A_div_dbz),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division, truncating toward zero, remainder follows dividend.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb, lq, lr;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[W-1:0];
            r  = lr[W-1:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start in the current cycle (cycle 0), follow to done, check everything.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input bit inject, input string name);
        logic [W-1:0] eq, er;
        int k;
        bit busy_bad;
        model(a, b, s, eq, er);
        A_div_start  = 1'b1;
        A_div_signed = s;
        A_div_src1   = a;
        A_div_src2   = b;
        k = 0;
        busy_bad = 0;
        while (k < 80) begin
            tick();
            k++;
            A_div_start  = inject && (k == 5 || k == 20);
            A_div_signed = $urandom_range(0, 1);
            A_div_src1   = $urandom;
            A_div_src2   = $urandom;
            if (A_div_done) break;
            if (A_div_busy !== 1'b1) busy_bad = 1;
        end
        A_div_start = 1'b0;
        if (A_div_busy !== 1'b0) busy_bad = 1;
        checks++;
        if (k != LAT) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles expected %0d", name, k, LAT);
        end
        checks++;
        if (busy_bad) begin
            errors++;
            $display("FAIL %s busy_window: busy not high exactly in cycles 1..%0d", name, LAT - 1);
        end
        checks++;
        if (A_div_quot !== eq) begin
            errors++;
            $display("FAIL %s quot: got %h expected %h", name, A_div_quot, eq);
        end
        checks++;
        if (A_div_rem !== er) begin
            errors++;
            $display("FAIL %s rem: got %h expected %h", name, A_div_rem, er);
        end
        checks++;
        if (A_div_dbz !== (b == 0)) begin
            errors++;
            $display("FAIL %s dbz: got %b expected %b", name, A_div_dbz, (b == 0));
        end
        tick();
        checks++;
        if (A_div_done !== 1'b0 || A_div_quot !== eq || A_div_rem !== er) begin
            errors++;
            $display("FAIL %s hold: got done=%b q=%h r=%h expected done=0 q=%h r=%h",
                     name, A_div_done, A_div_quot, A_div_rem, eq, er);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        A_div_start = 1'b0;
        A_div_signed = 1'b0;
        A_div_src1 = '0;
        A_div_src2 = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({A_div_busy, A_div_done, A_div_dbz} !== 3'b000 || A_div_quot !== '0 || A_div_rem !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b dbz=%b q=%h r=%h expected all zero",
                     A_div_busy, A_div_done, A_div_dbz, A_div_quot, A_div_rem);
        end
    endtask

    task automatic test_directed();
        do_op(32'd100, 32'd7, 1'b0, 0, "u100_7");
        do_op(32'hFFFFFFF9, 32'd2, 1'b1, 0, "s_m7_2");
        do_op(32'd7, 32'hFFFFFFFE, 1'b1, 0, "s_7_m2");
        do_op(32'hFFFFFFF9, 32'd2, 1'b0, 0, "u_big_2");
        do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, "s_min_m1");
        do_op(32'hFFFFFFFF, 32'd1, 1'b0, 0, "u_max_1");
    endtask

    task automatic test_dbz();
        do_op(32'd5, 32'd0, 1'b1, 0, "dbz_signed");
        do_op(32'd5, 32'd0, 1'b0, 0, "dbz_unsigned");
        do_op(32'hFFFFFFF6, 32'd0, 1'b1, 0, "dbz_neg");
        do_op(32'd9, 32'd4, 1'b0, 0, "dbz_clear");
    endtask

    task automatic test_ignored_start();
        do_op(32'd100, 32'd7, 1'b0, 1, "ignored_start");
        do_op(32'hFFFFFF00, 32'd3, 1'b1, 1, "ignored_start_s");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2, q1, r1, q2, r2;
        int k;
        a1 = $urandom; b1 = $urandom_range(1, 1000);
        a2 = $urandom; b2 = $urandom;
        model(a1, b1, 1'b0, q1, r1);
        model(a2, b2, 1'b1, q2, r2);
        A_div_start = 1'b1; A_div_signed = 1'b0; A_div_src1 = a1; A_div_src2 = b1;
        k = 0;
        while (k < 80) begin
            tick();
            k++;
            A_div_start = 1'b0;
            if (A_div_done) break;
        end
        checks++;
        if (k != LAT || A_div_quot !== q1 || A_div_rem !== r1) begin
            errors++;
            $display("FAIL b2b_first: got k=%0d q=%h r=%h expected k=%0d q=%h r=%h",
                     k, A_div_quot, A_div_rem, LAT, q1, r1);
        end
        A_div_start = 1'b1; A_div_signed = 1'b1; A_div_src1 = a2; A_div_src2 = b2;
        k = 0;
        while (k < 80) begin
            tick();
            k++;
            A_div_start = 1'b0;
            if (k == 1) begin
                checks++;
                if (A_div_busy !== 1'b1 || A_div_done !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0",
                             A_div_busy, A_div_done);
                end
            end
            if (A_div_done) break;
        end
        checks++;
        if (k != LAT || A_div_quot !== q2 || A_div_rem !== r2) begin
            errors++;
            $display("FAIL b2b_second: got k=%0d q=%h r=%h expected k=%0d q=%h r=%h",
                     k, A_div_quot, A_div_rem, LAT, q2, r2);
        end
        repeat (5) tick();
        checks++;
        if (A_div_quot !== q2 || A_div_rem !== r2 || A_div_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got q=%h r=%h busy=%b expected q=%h r=%h busy=0",
                     A_div_quot, A_div_rem, A_div_busy, q2, r2);
        end
    endtask

    task automatic test_reset_mid();
        bit done_seen;
        A_div_start = 1'b1; A_div_signed = 1'b0; A_div_src1 = 32'd1000; A_div_src2 = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            tick();
            A_div_start = 1'b0;
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({A_div_busy, A_div_done, A_div_dbz} !== 3'b000 || A_div_quot !== '0 || A_div_rem !== '0) begin
            errors++;
            $display("FAIL reset_mid_state: got busy=%b done=%b dbz=%b q=%h r=%h expected all zero",
                     A_div_busy, A_div_done, A_div_dbz, A_div_quot, A_div_rem);
        end
        reset = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 45; k++) begin
            tick();
            if (A_div_done || A_div_busy) done_seen = 1;
        end
        checks++;
        if (done_seen) begin
            errors++;
            $display("FAIL reset_mid_discard: got done/busy after reset expected none");
        end
        do_op(32'd9, 32'd3, 1'b0, 0, "after_reset_9_3");
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic s;
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            s = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom_range(1, 15) * ($urandom_range(0, 1) ? 32'hFFFFFFFF : 32'd1);
                2: b = '0;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            do_op(a, b, s, 0, $sformatf("random_%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_dbz();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
